// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the multicycle CPU controller.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    EXECUTE = 4'd2,
    ALUWB   = 4'd3,
    MEMADR  = 4'd4,
    MEMRD   = 4'd5,
    MEMWB   = 4'd6,
    MEMWR   = 4'd7,
    BRANCH  = 4'd8,
    HALT    = 4'd9
  } state_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [2:0] CMD_ADD = 3'b000;
  localparam logic [2:0] CMD_SUB = 3'b001;
  localparam logic [2:0] CMD_AND = 3'b010;
  localparam logic [2:0] CMD_ORR = 3'b011;
  localparam logic [2:0] CMD_CMP = 3'b100;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/mc_instr_decode.sv
// Combinational field decode of the upper instruction byte (Instr[25:18]).
module mc_instr_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 3
) (
  input  logic [7:0]           fields,
  output logic                 cond,
  output logic [1:0]           op,
  output logic                 i_bit,
  output logic                 sl_bit,
  output logic [ALUCTRL_W-1:0] alu_ctrl,
  output logic                 no_write,
  output logic                 flag_load,
  output logic [1:0]           imm_src
);

  logic [2:0] cmd;
  logic [2:0] alu_code;
  logic       is_cmp;
  logic       is_nop;

  // Split fields, map cmd to ALU op, classify non-writing commands
  always_comb begin
    cond     = fields[7];
    op       = fields[6:5];
    i_bit    = fields[4];
    cmd      = fields[3:1];
    sl_bit   = fields[0];
    alu_code = ALU_ADD;
    is_cmp   = 1'b0;
    is_nop   = 1'b0;
    case (cmd)
      CMD_ADD: alu_code = ALU_ADD;
      CMD_SUB: alu_code = ALU_SUB;
      CMD_AND: alu_code = ALU_AND;
      CMD_ORR: alu_code = ALU_ORR;
      CMD_CMP: begin
        alu_code = ALU_SUB;
        is_cmp   = 1'b1;
      end
      default: begin
        alu_code = ALU_ADD;
        is_nop   = 1'b1;
      end
    endcase
    alu_ctrl  = ALUCTRL_W'(alu_code);
    no_write  = is_cmp | is_nop;
    flag_load = is_cmp | (sl_bit & ~is_nop);
    case (op)
      OP_MEM:  imm_src = 2'b01;
      OP_BR:   imm_src = 2'b10;
      default: imm_src = 2'b00;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle controller: FSM, condition flags and memory wait watchdog.
module multicycle_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 3,
  parameter int MAX_WAIT  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [15:0]          Instr,
  input  logic [3:0]           ALUFlags,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 PCWrite,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic                 MemWrite,
  output logic                 AdrSrc,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           RegSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 mem_err,
  output logic [3:0]           state_o
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  state_t              state, state_next;
  logic [3:0]          flags;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                wait_hit;
  logic                fault;

  logic                cond;
  logic [1:0]          op;
  logic                i_bit;
  logic                sl_bit;
  logic [ALUCTRL_W-1:0] alu_ctrl;
  logic                no_write;
  logic                flag_load;
  logic [1:0]          imm_src;

  logic                unused_ok;
  assign unused_ok = ^{Instr[7:0], flags[FLAG_N], flags[FLAG_C], flags[FLAG_V]};

  mc_instr_decode #(.ALUCTRL_W(ALUCTRL_W)) u_dec (
    .fields    (Instr[15:8]),
    .cond      (cond),
    .op        (op),
    .i_bit     (i_bit),
    .sl_bit    (sl_bit),
    .alu_ctrl  (alu_ctrl),
    .no_write  (no_write),
    .flag_load (flag_load),
    .imm_src   (imm_src)
  );

  // Fault fires on the last permitted wait cycle; a same-cycle mem_ready wins
  assign wait_hit = !mem_ready && (wait_cnt == WAIT_W'(MAX_WAIT - 1));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= state_next;
  end

  // Condition flags, loaded from the ALU at the end of EXECUTE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                flags <= '0;
    else if (state == EXECUTE && flag_load)    flags <= ALUFlags;
  end

  // Wait counter clears on any state change; sticky fault flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      if (state_next != state)         wait_cnt <= '0;
      else if (mem_req && !mem_ready)  wait_cnt <= wait_cnt + 1'b1;
      if (fault)                       mem_err  <= 1'b1;
    end
  end

  // Next-state and output decode; everything held low while reset is asserted
  always_comb begin
    state_next = state;
    fault      = 1'b0;
    mem_req    = 1'b0;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ImmSrc     = 2'b00;
    RegSrc     = 2'b00;
    ALUControl = ALUCTRL_W'(ALU_ADD);
    state_o    = state;
    if (reset) begin
      case (state)
        FETCH: begin
          mem_req   = 1'b1;
          ALUSrcA   = 1'b1;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
          IRWrite   = mem_ready;
          PCWrite   = mem_ready;
          if (mem_ready)     state_next = DECODE;
          else if (wait_hit) begin
            state_next = HALT;
            fault      = 1'b1;
          end
        end
        DECODE: begin
          ALUSrcA   = 1'b1;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
          if ((cond && !flags[FLAG_Z]) || op == 2'b11) state_next = FETCH;
          else if (op == OP_DP)                        state_next = EXECUTE;
          else if (op == OP_MEM)                       state_next = MEMADR;
          else                                         state_next = BRANCH;
        end
        EXECUTE: begin
          ALUSrcB    = i_bit ? 2'b01 : 2'b00;
          ALUControl = alu_ctrl;
          state_next = no_write ? FETCH : ALUWB;
        end
        ALUWB: begin
          RegWrite   = 1'b1;
          state_next = FETCH;
        end
        MEMADR: begin
          ALUSrcB    = 2'b01;
          ImmSrc     = imm_src;
          state_next = sl_bit ? MEMRD : MEMWR;
        end
        MEMRD: begin
          mem_req = 1'b1;
          AdrSrc  = 1'b1;
          if (mem_ready)     state_next = MEMWB;
          else if (wait_hit) begin
            state_next = HALT;
            fault      = 1'b1;
          end
        end
        MEMWB: begin
          RegWrite   = 1'b1;
          ResultSrc  = 2'b01;
          state_next = FETCH;
        end
        MEMWR: begin
          mem_req  = 1'b1;
          AdrSrc   = 1'b1;
          RegSrc   = 2'b10;
          MemWrite = 1'b1;
          if (mem_ready)     state_next = FETCH;
          else if (wait_hit) begin
            state_next = HALT;
            fault      = 1'b1;
          end
        end
        BRANCH: begin
          ALUSrcB    = 2'b01;
          ImmSrc     = imm_src;
          ResultSrc  = 2'b10;
          PCWrite    = 1'b1;
          state_next = FETCH;
        end
        HALT:    state_next = HALT;
        default: state_next = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: vector table plus corner sequences.
module tb_multicycle_controller;

  logic        clk;
  logic        reset;
  logic [15:0] Instr;
  logic [3:0]  ALUFlags;
  logic        mem_ready;
  logic        mem_req, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA;
  logic [1:0]  ALUSrcB, ResultSrc, ImmSrc, RegSrc;
  logic [2:0]  ALUControl;
  logic        mem_err;
  logic [3:0]  state_o;

  multicycle_controller #(.ALUCTRL_W(3), .MAX_WAIT(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .Instr      (Instr),
    .ALUFlags   (ALUFlags),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .PCWrite    (PCWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .MemWrite   (MemWrite),
    .AdrSrc     (AdrSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc),
    .ALUControl (ALUControl),
    .mem_err    (mem_err),
    .state_o    (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {state, req, pcw, irw, rw, mw, adr, srca, srcb, res, imm, regsrc, alu, err}
  logic [22:0] act;
  assign act = {state_o, mem_req, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
                ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, mem_err};

  localparam logic [22:0] E_RST = 23'd0;
  localparam logic [22:0] E_FW  = {4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b10, 2'b00, 2'b00, 3'b000, 1'b0};
  localparam logic [22:0] E_FR  = {4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b10, 2'b00, 2'b00, 3'b000, 1'b0};
  localparam logic [22:0] E_DEC = {4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b10, 2'b00, 2'b00, 3'b000, 1'b0};
  localparam logic [22:0] E_WB  = {4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0};
  localparam logic [22:0] E_MA  = {4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b01, 2'b00, 3'b000, 1'b0};
  localparam logic [22:0] E_MR  = {4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0};
  localparam logic [22:0] E_MWB = {4'd6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 3'b000, 1'b0};
  localparam logic [22:0] E_MW  = {4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b10, 3'b000, 1'b0};
  localparam logic [22:0] E_BR  = {4'd8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b10, 2'b00, 3'b000, 1'b0};
  localparam logic [22:0] E_HLT = {4'd9, 18'd0, 1'b1};

  // Instruction encodings: {COND, op, I, cmd, S/L, Rd, 4'b0}
  localparam logic [15:0] I_ADDI = 16'h1110; // ADD imm, S=1
  localparam logic [15:0] I_SUB  = 16'h0200; // SUB reg, S=0
  localparam logic [15:0] I_AND  = 16'h0400;
  localparam logic [15:0] I_ORR  = 16'h0600;
  localparam logic [15:0] I_CMP  = 16'h1900; // CMP imm
  localparam logic [15:0] I_NOP  = 16'h0C10; // cmd=110, S=0
  localparam logic [15:0] I_BEQ  = 16'hC000; // branch if Z
  localparam logic [15:0] I_B    = 16'h4000; // branch always
  localparam logic [15:0] I_RSV  = 16'h6000; // op=11
  localparam logic [15:0] I_LDR  = 16'h3120;
  localparam logic [15:0] I_STR  = 16'h3030;

  function automatic logic [22:0] ex(input logic [1:0] srcb, input logic [2:0] alu);
    ex = {4'd2, 7'b0, srcb, 2'b00, 2'b00, 2'b00, alu, 1'b0};
  endfunction

  typedef struct {
    logic [15:0] instr;
    logic [3:0]  flg;
    logic        rdy;
    logic [22:0] exp;
  } vec_t;

  vec_t        tbl[$];
  logic [22:0] exp_q[$];
  int          total = 0;
  int          bad   = 0;

  function automatic void add(input logic [15:0] i, input logic [3:0] f, input logic r,
                              input logic [22:0] e);
    vec_t v;
    v.instr = i; v.flg = f; v.rdy = r; v.exp = e;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [22:0] got, input logic [22:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (state got=%0d exp=%0d)", nm, got, want, got[22:19], want[22:19]);
    end
  endtask

  // Drive one cycle of inputs, queue the expectation, compare at the falling edge
  task automatic step(input logic [15:0] i, input logic [3:0] f, input logic r,
                      input logic [22:0] e, input string nm);
    Instr     = i;
    ALUFlags  = f;
    mem_ready = r;
    exp_q.push_back(e);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s scoreboard empty", nm);
    end else begin
      chk(nm, act, exp_q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string nm);
    reset     = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    chk(nm, act, E_RST);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; Instr = '0; ALUFlags = '0; mem_ready = 1'b0;

    // ADD imm S=1 loads Z, so the following conditional branch is taken
    add(I_ADDI, 4'b0100, 1, E_FR); add(I_ADDI, 4'b0100, 1, E_DEC);
    add(I_ADDI, 4'b0100, 1, ex(2'b01, 3'b000)); add(I_ADDI, 4'b0100, 1, E_WB);
    add(I_BEQ, 4'b0000, 1, E_FR); add(I_BEQ, 4'b0000, 1, E_DEC); add(I_BEQ, 4'b0000, 1, E_BR);
    // SUB with S=0 leaves Z set
    add(I_SUB, 4'b0000, 1, E_FR); add(I_SUB, 4'b0000, 1, E_DEC);
    add(I_SUB, 4'b0000, 1, ex(2'b00, 3'b001)); add(I_SUB, 4'b0000, 1, E_WB);
    add(I_BEQ, 4'b0000, 1, E_FR); add(I_BEQ, 4'b0000, 1, E_DEC); add(I_BEQ, 4'b0000, 1, E_BR);
    add(I_AND, 4'b0000, 1, E_FR); add(I_AND, 4'b0000, 1, E_DEC);
    add(I_AND, 4'b0000, 1, ex(2'b00, 3'b010)); add(I_AND, 4'b0000, 1, E_WB);
    add(I_ORR, 4'b0000, 1, E_FR); add(I_ORR, 4'b0000, 1, E_DEC);
    add(I_ORR, 4'b0000, 1, ex(2'b00, 3'b011)); add(I_ORR, 4'b0000, 1, E_WB);
    // CMP clears Z: no writeback, branch not taken
    add(I_CMP, 4'b0000, 1, E_FR); add(I_CMP, 4'b0000, 1, E_DEC);
    add(I_CMP, 4'b0000, 1, ex(2'b01, 3'b001));
    add(I_BEQ, 4'b0100, 1, E_FR); add(I_BEQ, 4'b0100, 1, E_DEC);
    // cmd=110 NOP, S=0: no writeback, flags untouched
    add(I_NOP, 4'b0100, 1, E_FR); add(I_NOP, 4'b0100, 1, E_DEC);
    add(I_NOP, 4'b0100, 1, ex(2'b00, 3'b000));
    add(I_BEQ, 4'b0100, 1, E_FR); add(I_BEQ, 4'b0100, 1, E_DEC);
    // reserved op
    add(I_RSV, 4'b0100, 1, E_FR); add(I_RSV, 4'b0100, 1, E_DEC);
    // LDR with ready delayed 3 cycles in MEMRD
    add(I_LDR, 4'b0000, 1, E_FR); add(I_LDR, 4'b0000, 1, E_DEC); add(I_LDR, 4'b0000, 1, E_MA);
    add(I_LDR, 4'b0000, 0, E_MR); add(I_LDR, 4'b0000, 0, E_MR); add(I_LDR, 4'b0000, 0, E_MR);
    add(I_LDR, 4'b0000, 1, E_MR); add(I_LDR, 4'b0000, 1, E_MWB);
    // STR with one wait cycle
    add(I_STR, 4'b0000, 1, E_FR); add(I_STR, 4'b0000, 1, E_DEC); add(I_STR, 4'b0000, 1, E_MA);
    add(I_STR, 4'b0000, 0, E_MW); add(I_STR, 4'b0000, 1, E_MW);
    // fetch waits, then unconditional branch
    add(I_B, 4'b0000, 0, E_FW); add(I_B, 4'b0000, 0, E_FW); add(I_B, 4'b0000, 1, E_FR);
    add(I_B, 4'b0000, 1, E_DEC); add(I_B, 4'b0000, 1, E_BR);

    do_reset("reset_init");
    for (int k = 0; k < tbl.size(); k++)
      step(tbl[k].instr, tbl[k].flg, tbl[k].rdy, tbl[k].exp, $sformatf("tbl%0d", k));

    // Watchdog: STR never completes -> HALT with mem_err after 16 wait cycles
    step(I_STR, 4'b0000, 1, E_FR, "wd_fetch");
    step(I_STR, 4'b0000, 1, E_DEC, "wd_dec");
    step(I_STR, 4'b0000, 1, E_MA, "wd_adr");
    for (int n = 1; n <= 16; n++)
      step(I_STR, 4'b0000, 0, E_MW, $sformatf("wd_wait%0d", n));
    step(I_STR, 4'b0000, 0, E_HLT, "wd_halt");
    step(I_STR, 4'b0000, 1, E_HLT, "wd_halt_stays");
    do_reset("wd_reset_clears");

    // mem_ready on exactly the 16th wait cycle completes normally
    step(I_STR, 4'b0000, 1, E_FR, "edge_fetch");
    step(I_STR, 4'b0000, 1, E_DEC, "edge_dec");
    step(I_STR, 4'b0000, 1, E_MA, "edge_adr");
    for (int n = 1; n <= 15; n++)
      step(I_STR, 4'b0000, 0, E_MW, $sformatf("edge_wait%0d", n));
    step(I_STR, 4'b0000, 1, E_MW, "edge_ready16");
    step(I_RSV, 4'b0000, 1, E_FR, "edge_no_fault");
    step(I_RSV, 4'b0000, 1, E_DEC, "edge_dec2");

    // Set Z, then reset asynchronously in the middle of a store wait
    step(I_CMP, 4'b0100, 1, E_FR, "ar_cmp_fetch");
    step(I_CMP, 4'b0100, 1, E_DEC, "ar_cmp_dec");
    step(I_CMP, 4'b0100, 1, ex(2'b01, 3'b001), "ar_cmp_exec");
    step(I_STR, 4'b0000, 1, E_FR, "ar_fetch");
    step(I_STR, 4'b0000, 1, E_DEC, "ar_dec");
    step(I_STR, 4'b0000, 1, E_MA, "ar_adr");
    step(I_STR, 4'b0000, 0, E_MW, "ar_wait1");
    Instr = I_STR; mem_ready = 1'b0;
    #1;
    chk("ar_before", act, E_MW);
    reset = 1'b0;
    #1;
    chk("ar_async", act, E_RST);
    @(posedge clk);
    #1;
    reset = 1'b1;
    // flags were cleared, so the conditional branch falls through
    step(I_BEQ, 4'b0000, 1, E_FR, "ar_beq_fetch");
    step(I_BEQ, 4'b0000, 1, E_DEC, "ar_beq_dec");
    step(I_B, 4'b0000, 1, E_FR, "ar_resume");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multicycle successor to the single-cycle CPU controller: one FSM sequences fetch/decode/execute/memory/writeback over several cycles.
- Shares one memory port, which is handshaked via mem_req/mem_ready, with a wait watchdog.
- Holds the condition flags internally and gates execution with the instruction's condition bit.
- Sits between the datapath (instruction register, ALU, register file, PC) and the unified instruction/data memory.

Parameters:
- ALUCTRL_W, 3: width of ALUControl; command code is zero-extended into it (must be ≥3).
- MAX_WAIT, 16: maximum cycles mem_req may stay high without mem_ready before fault.
- WAIT_W, $clog2(MAX_WAIT+1): wait-counter width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- Instr  in  16  instruction fields [25:10] from IR. Field layout:
  - [25] COND: 0 = always; 1 = execute only if Z.
  - [24:23] op: 00 DP, 01 MEM, 10 BRANCH, 11 reserved.
  - [22:18] funct: [22] I, [21:19] cmd, [18] S for DP / L for MEM.
  - [17:14] Rd.
- ALUFlags  in  4  {N,Z,C,V} from the ALU, current cycle.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA  out  1 each  datapath strobes/selects.
- ALUSrcB, ResultSrc, ImmSrc, RegSrc  out  2 each  datapath selects.
- ALUControl  out  ALUCTRL_W  ALU operation.
- mem_err  out  1  sticky watchdog fault.
- state_o  out  4  current state for debug.

Behaviour:
- Reset (async, reset==0):
  - State = FETCH, flags = 0, wait counter = 0, mem_err = 0.
  - All strobes 0, all selects 0.
  - Mid-access reset abandons the access; mem_req drops immediately.
- All outputs are a Moore decode of state and latched Instr. Exceptions: PCWrite and IRWrite in FETCH, and the branch PCWrite, also depend on mem_ready / the condition.
- States and transitions:
  - FETCH: mem_req=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10. On mem_ready: IRWrite=1, PCWrite=1 (PC+4), go to DECODE. Otherwise stay.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10 (PC+8 into the read path). If cond fails (COND=1 and Z=0) or op=11, go to FETCH. Otherwise DP → EXECUTE, MEM → MEMADR, BRANCH → BRANCH.
  - EXECUTE:
    - ALUSrcA=0; ALUSrcB=01 if I, else 00.
    - ALUControl per cmd: 000 ADD, 001 SUB, 010 AND, 011 ORR, 100 CMP (drives SUB, no write). Codes 101–111 drive ADD and are treated as NOP.
    - Go to ALUWB, except CMP/NOP go to FETCH.
    - Flags load ALUFlags at this edge iff S=1 (CMP always loads).
  - ALUWB: RegWrite=1, ResultSrc=00, go to FETCH.
  - MEMADR: ALUSrcA=0, ALUSrcB=01, ImmSrc=01, ADD. Go to MEMRD if L, else MEMWR.
  - MEMRD: mem_req=1, AdrSrc=1. On mem_ready go to MEMWB.
  - MEMWB: RegWrite=1, ResultSrc=01, go to FETCH.
  - MEMWR: mem_req=1, AdrSrc=1, RegSrc=10, MemWrite=1 while waiting. On mem_ready go to FETCH.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ImmSrc=10, ADD, ResultSrc=10, PCWrite=1, go to FETCH.
  - HALT: all strobes 0, mem_req=0. Exits only by reset.
- ImmSrc=00 and RegSrc=00 unless stated.
- Watchdog:
  - Counter clears on entry to any request state and increments each cycle mem_req=1 && mem_ready=0.
  - When count reaches MAX_WAIT with mem_ready still 0: mem_err←1, go to HALT.
  - mem_ready in the same cycle the count hits MAX_WAIT wins: normal transition, no fault.
- The condition is evaluated only in DECODE against the registered flags; flags written in EXECUTE are visible to the next instruction.
- No back-to-back fetch overlap; one instruction in flight.

Decomposition:
- Package cpu_ctrl_pkg:
  - state_t enum: FETCH=0, DECODE, EXECUTE, ALUWB, MEMADR, MEMRD, MEMWB, MEMWR, BRANCH, HALT.
  - op codes (OP_DP/OP_MEM/OP_BR).
  - ALU command constants.
  - Flag bit indices (N=3, Z=2, C=1, V=0).
- One sub-module: mc_instr_decode. Combinational: Instr → op, I, S/L, cmd-to-ALUControl, no_write, imm_src.
- The FSM, flag register, and watchdog stay in the top.

Test Plan:
- ADD R1 imm (op=00, I=1, cmd=000, S=1), mem_ready tied 1 → FETCH, DECODE, EXECUTE, ALUWB, FETCH. RegWrite=1 only in ALUWB. Flags load ALUFlags=4'b0100.
- LDR (op=01, L=1), mem_ready delayed 3 cycles in MEMRD → MEMRD held 4 cycles with mem_req=1, then MEMWB RegWrite=1 and ResultSrc=01. Total 8 cycles with fetch ready at 1 cycle.
- CMP setting Z=1, then conditional branch COND=1 → BRANCH taken, PCWrite in BRANCH. Repeat with ALUFlags Z=0: DECODE→FETCH, no PCWrite.
- STR with mem_ready never asserted, MAX_WAIT=16 → mem_err=1 after 16 wait cycles, state_o=HALT, MemWrite and mem_req=0 thereafter. mem_ready at exactly cycle 16 → no fault.
- Reset asserted (reset=0) in MEMWR mid-wait → asynchronously mem_req=0, MemWrite=0, state_o=FETCH, flags=0. After release, fetch resumes.
- op=11 and cmd=110 → return to FETCH with no RegWrite, MemWrite or flag change.
